// File: rtl/addr_dec_resp_pkg.sv
// Shared constants, types and helpers for the TCDM address decoder with buffered response path.
package addr_dec_resp_pkg;

    localparam int unsigned DefNumSlave      = 32;
    localparam int unsigned DefReqDataWidth  = 32;
    localparam int unsigned DefRespDataWidth = 32;
    localparam int unsigned DefRespLat       = 1;
    localparam int unsigned DefRespFifoDepth = 2;

    // Which requests return a response: reads only, or reads and writes.
    typedef enum logic {
        RESP_READ_ONLY = 1'b0,
        RESP_ALL       = 1'b1
    } resp_mode_e;

    // Bits needed to count from 0 up to and including depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/addr_dec_resp_buf_chk.sv
// Invariants of the credit scheme: the buffer never overflows, credits stay
// within the buffer depth and buffered entries never outnumber credits.
module addr_dec_resp_buf_chk #(
    parameter int unsigned CntW  = 2,
    parameter int unsigned Depth = 2
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            push_i,
    input logic            full_i,
    input logic [CntW-1:0] cnt_i,
    input logic [CntW-1:0] usage_i
);

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full_i));

    a_cnt_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_i <= CntW'(Depth));

    a_usage_within_credit: assert property (@(posedge clk_i) disable iff (rst_i)
        usage_i <= cnt_i);

endmodule

// File: rtl/resp_fifo.sv
// Response buffer: circular FIFO with occupancy count. Pushes while full and
// pops while empty are ignored; the head reads as zero when empty.
module resp_fifo
    import addr_dec_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned UsageW    = cnt_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [UsageW-1:0]     usage_o
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PtrW-1:0]       wr_ptr_r;
    logic [PtrW-1:0]       rd_ptr_r;
    logic [UsageW-1:0]     usage_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Advance a pointer, wrapping at the last slot.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PtrW'(1);
        end
    endfunction

    // Status flags, qualified handshakes and head data.
    always_comb begin
        full_o    = (usage_r == UsageW'(DEPTH));
        empty_o   = (usage_r == '0);
        usage_o   = usage_r;
        do_push_s = push_i & ~full_o;
        do_pop_s  = pop_i & ~empty_o;
        if (empty_o) begin
            data_o = '0;
        end else begin
            data_o = mem_r[rd_ptr_r];
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            usage_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   usage_r <= usage_r + UsageW'(1);
                2'b01:   usage_r <= usage_r - UsageW'(1);
                default: usage_r <= usage_r;
            endcase
        end
    end

endmodule

// File: rtl/addr_dec_resp_buf.sv
// Single-master address decoder with credit-throttled, buffered response path.
// Slave responses come back a fixed RespLat cycles after grant and cannot be
// stalled, so a buffer slot (credit) is reserved before a request is issued.
// Optional: ADDR_DEC_RESP_BUF_BYPASS_EN forwards a response straight to the
// master in its capture cycle when the buffer is empty and the master is ready.
module addr_dec_resp_buf
    import addr_dec_resp_pkg::*;
#(
    parameter int unsigned NumSlave      = DefNumSlave,
    parameter int unsigned ReqDataWidth  = DefReqDataWidth,
    parameter int unsigned RespDataWidth = DefRespDataWidth,
    parameter int unsigned RespLat       = DefRespLat,
    parameter int unsigned WriteRespOn   = 1,
    parameter int unsigned RespFifoDepth = DefRespFifoDepth,
    localparam int unsigned AddrW        = $clog2(NumSlave)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    req_i,
    input  logic [AddrW-1:0]                        add_i,
    input  logic                                    wen_i,
    input  logic [ReqDataWidth-1:0]                 data_i,
    output logic                                    gnt_o,
    output logic                                    vld_o,
    input  logic                                    rready_i,
    output logic [RespDataWidth-1:0]                rdata_o,
    output logic [NumSlave-1:0]                     req_o,
    input  logic [NumSlave-1:0]                     gnt_i,
    output logic [NumSlave-1:0][ReqDataWidth-1:0]   data_o,
    input  logic [NumSlave-1:0][RespDataWidth-1:0]  rdata_i
);

    localparam int unsigned CntW     = cnt_width(RespFifoDepth);
    localparam logic [CntW-1:0] DepthC = CntW'(RespFifoDepth);
    localparam resp_mode_e RespMode  = (WriteRespOn != 0) ? RESP_ALL : RESP_READ_ONLY;

    logic [CntW-1:0]          cnt_r;
    logic [RespLat-1:0]       pipe_vld_r;
    logic [AddrW-1:0]         pipe_sel_r [RespLat];
    logic                     needs_resp_s;
    logic                     can_issue_s;
    logic                     issue_s;
    logic                     cap_vld_s;
    logic [RespDataWidth-1:0] cap_data_s;
    logic                     bypass_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     resp_taken_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [RespDataWidth-1:0] fifo_head_s;
    logic [CntW-1:0]          fifo_usage_s;

    // Request side: credit check on the registered count, decode, grant.
    always_comb begin
        needs_resp_s = ~wen_i | (RespMode == RESP_ALL);
        can_issue_s  = ~needs_resp_s | (cnt_r < DepthC);
        req_o        = '0;
        req_o[add_i] = req_i & can_issue_s;
        gnt_o        = can_issue_s & (|gnt_i);
        issue_s      = req_i & gnt_o;
        for (int i = 0; i < int'(NumSlave); i++) begin
            data_o[i] = data_i;
        end
    end

    // Response side: capture from the selected bank, optional bypass, master handshake.
    always_comb begin
        cap_vld_s  = pipe_vld_r[RespLat-1];
        cap_data_s = rdata_i[pipe_sel_r[RespLat-1]];
`ifdef ADDR_DEC_RESP_BUF_BYPASS_EN
        bypass_s   = cap_vld_s & fifo_empty_s & rready_i;
`else
        bypass_s   = 1'b0;
`endif
        push_s     = cap_vld_s & ~bypass_s;
        pop_s      = ~fifo_empty_s & rready_i;
        vld_o      = ~fifo_empty_s | bypass_s;
        if (~fifo_empty_s) begin
            rdata_o = fifo_head_s;
        end else if (bypass_s) begin
            rdata_o = cap_data_s;
        end else begin
            rdata_o = '0;
        end
        resp_taken_s = vld_o & rready_i;
    end

    // Fixed-latency tracker of which bank answers in which cycle; never stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld_r <= '0;
            for (int i = 0; i < int'(RespLat); i++) begin
                pipe_sel_r[i] <= '0;
            end
        end else begin
            pipe_vld_r[0] <= issue_s & needs_resp_s;
            pipe_sel_r[0] <= add_i;
            for (int i = 1; i < int'(RespLat); i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_sel_r[i] <= pipe_sel_r[i-1];
            end
        end
    end

    // Credits: taken when a response-bearing request issues, returned when the master takes a response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else begin
            case ({issue_s & needs_resp_s, resp_taken_s})
                2'b10:   cnt_r <= cnt_r + CntW'(1);
                2'b01:   cnt_r <= cnt_r - CntW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    resp_fifo #(
        .DATA_WIDTH (RespDataWidth),
        .DEPTH      (RespFifoDepth)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .data_i  (cap_data_s),
        .pop_i   (pop_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .usage_o (fifo_usage_s)
    );

    addr_dec_resp_buf_chk #(
        .CntW  (CntW),
        .Depth (RespFifoDepth)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .full_i  (fifo_full_s),
        .cnt_i   (cnt_r),
        .usage_i (fifo_usage_s)
    );

endmodule
